// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Master identifier: one bit selects between the two upstream ports.
    typedef logic mst_id_t;

    localparam mst_id_t MST_I = 1'b0;  // instruction-fetch port (m0)
    localparam mst_id_t MST_D = 1'b1;  // data port (m1)

    // Round-robin successor: after serving one master, prefer the other.
    function automatic mst_id_t rr_next(input mst_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Ordered record of which master owns each outstanding RAM transfer.
// Latency: head is combinational from storage; push visible at head next cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  mst_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output mst_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mst_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths would also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the push lands in, so push+pop is fine when full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset discards all outstanding IDs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ID storage written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MST_I;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Round-robin 2:1 arbiter in front of a single-port RAM with in-order response routing.
// Latency: zero added cycles on request and response paths (combinational muxing).
// Backpressure: a stalled request is held on its master; no issue while the ID FIFO is full.
module mem_arbiter_2to1
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    s_req_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,

    output logic                    err_o
);

    mst_id_t rr_ptr_q, rr_ptr_d;
    logic    lock_q, lock_d;
    mst_id_t lock_id_q, lock_id_d;

    mst_id_t sel;
    logic    sel_req;
    logic    can_issue;
    logic    accept;
    logic    fifo_full, fifo_empty;
    logic    pop;
    mst_id_t head;

    // Selection: a stalled request keeps its master; otherwise round-robin on contention.
    always_comb begin
        sel = MST_I;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = rr_ptr_q;
        end else if (m1_req_i) begin
            sel = MST_D;
        end else begin
            sel = MST_I;
        end
    end

    // A response retiring this cycle frees its FIFO slot for a same-cycle issue.
    assign pop       = s_rvalid_i & ~fifo_empty;
    assign can_issue = ~fifo_full | pop;
    assign sel_req   = (sel == MST_D) ? m1_req_i : m0_req_i;

    // Reset gates every handshake output so nothing leaks out while rst_n is low.
    assign s_req_o   = rst_n & sel_req & can_issue;
    assign accept    = s_req_o & s_gnt_i;

    // Payload follows the selected master even when no request is presented.
    assign s_addr_o  = (sel == MST_D) ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = (sel == MST_D) ? m1_we_i    : m0_we_i;
    assign s_wdata_o = (sel == MST_D) ? m1_wdata_i : m0_wdata_i;
    assign s_be_o    = (sel == MST_D) ? m1_be_i    : m0_be_i;

    assign m0_gnt_o  = accept & (sel == MST_I);
    assign m1_gnt_o  = accept & (sel == MST_D);

    // Responses go to whichever master owns the oldest outstanding transfer.
    assign m0_rvalid_o = rst_n & pop & (head == MST_I);
    assign m1_rvalid_o = rst_n & pop & (head == MST_D);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    // A response with nothing outstanding is flagged and otherwise ignored.
    assign err_o = rst_n & s_rvalid_i & fifo_empty;

    // Next-state for the round-robin pointer and the stall lock.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            rr_ptr_d = rr_next(sel);
            lock_d   = 1'b0;
        end else if (s_req_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (lock_q && !sel_req) begin
            // Locked master withdrew (protocol violation): release so the port cannot wedge.
            lock_d = 1'b0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= MST_I;
            lock_q    <= 1'b0;
            lock_id_q <= MST_I;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (accept),
        .push_id_i (sel),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head)
    );

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed self-checking bench for the 2:1 RAM arbiter.
// Latency: checks combinational outputs 2 time units after each rising edge.
// Backpressure: RAM grant/rvalid are driven per cycle by the vectors.
module tb_mem_arbiter_2to1;

    logic        clk;
    logic        rst_n;
    logic        m0_req_i, m1_req_i;
    logic [7:0]  m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_gnt_o, m1_gnt_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o;
    logic [7:0]  s_addr_o;
    logic        s_we_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        err_o;

    int n_vec  = 0;
    int n_bad  = 0;

    mem_arbiter_2to1 #(
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req_i    (m0_req_i),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_be_i     (m0_be_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_be_i     (m1_be_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .s_req_o     (s_req_o),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_gnt_i     (s_gnt_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (safe point to drive inputs).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i   = 1'b0; m1_req_i   = 1'b0;
        m0_we_i    = 1'b0; m1_we_i    = 1'b0;
        m0_addr_i  = 8'h00; m1_addr_i = 8'h00;
        m0_wdata_i = '0;   m1_wdata_i = '0;
        m0_be_i    = 4'h0; m1_be_i    = 4'h0;
        s_gnt_i    = 1'b0; s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;

        // ---- Reset: outputs forced low even with a request and stray rvalid present.
        m0_req_i   = 1'b1;
        s_gnt_i    = 1'b1;
        s_rvalid_i = 1'b1;
        settle();
        chk("rst_s_req",  {31'b0, s_req_o},  32'd0);
        chk("rst_m0_gnt", {31'b0, m0_gnt_o}, 32'd0);
        chk("rst_err",    {31'b0, err_o},    32'd0);
        chk("rst_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        do_reset();

        // ---- Single m0 read, immediate grant, response next cycle.
        m0_req_i  = 1'b1;
        m0_addr_i = 8'h10;
        s_gnt_i   = 1'b1;
        settle();
        chk("t1_s_req",  {31'b0, s_req_o},  32'd1);
        chk("t1_s_addr", {24'b0, s_addr_o}, 32'h10);
        chk("t1_m0_gnt", {31'b0, m0_gnt_o}, 32'd1);
        chk("t1_m1_gnt", {31'b0, m1_gnt_o}, 32'd0);
        next_cycle();
        m0_req_i   = 1'b0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEADBEEF;
        settle();
        chk("t1_m0_rvalid", {31'b0, m0_rvalid_o}, 32'd1);
        chk("t1_m0_rdata",  m0_rdata_o,           32'hDEADBEEF);
        chk("t1_m1_rvalid", {31'b0, m1_rvalid_o}, 32'd0);
        chk("t1_err",       {31'b0, err_o},       32'd0);
        next_cycle();
        idle_inputs();

        // ---- Both masters streaming: alternate grants, responses follow one cycle later.
        do_reset();
        m0_req_i  = 1'b1; m0_addr_i = 8'h20; m0_we_i = 1'b0; m0_be_i = 4'h3;
        m0_wdata_i = 32'h0000_0A0A;
        m1_req_i  = 1'b1; m1_addr_i = 8'h30; m1_we_i = 1'b1; m1_be_i = 4'hF;
        m1_wdata_i = 32'hCAFE_0001;
        s_gnt_i   = 1'b1;
        for (int c = 0; c < 7; c++) begin
            s_rvalid_i = (c > 0);
            s_rdata_i  = 32'h100 + 32'(c);
            if (c == 6) begin
                m0_req_i = 1'b0;
                m1_req_i = 1'b0;
            end
            settle();
            if (c < 6) begin
                chk("t2_m0_gnt", {31'b0, m0_gnt_o}, {31'b0, (c % 2) == 0});
                chk("t2_m1_gnt", {31'b0, m1_gnt_o}, {31'b0, (c % 2) == 1});
                chk("t2_s_addr", {24'b0, s_addr_o}, ((c % 2) == 0) ? 32'h20 : 32'h30);
                chk("t2_s_we",   {31'b0, s_we_o},   {31'b0, (c % 2) == 1});
                chk("t2_s_be",   {28'b0, s_be_o},   ((c % 2) == 0) ? 32'h3 : 32'hF);
                chk("t2_s_wdata", s_wdata_o, ((c % 2) == 0) ? 32'h0000_0A0A : 32'hCAFE_0001);
            end
            if (c > 0) begin
                chk("t2_m0_rvalid", {31'b0, m0_rvalid_o}, {31'b0, ((c - 1) % 2) == 0});
                chk("t2_m1_rvalid", {31'b0, m1_rvalid_o}, {31'b0, ((c - 1) % 2) == 1});
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        chk("t2_drained_err", {31'b0, err_o}, 32'd0);

        // ---- Stall: m1 locked while RAM withholds grant, m0 joins and must wait.
        do_reset();
        m1_req_i  = 1'b1; m1_addr_i = 8'h44;
        m0_addr_i = 8'h40;
        s_gnt_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m0_req_i = (c > 0);
            settle();
            chk("t3_stall_addr", {24'b0, s_addr_o}, 32'h44);
            chk("t3_stall_req",  {31'b0, s_req_o},  32'd1);
            chk("t3_stall_gnt",  {30'b0, m1_gnt_o, m0_gnt_o}, 32'd0);
            next_cycle();
        end
        s_gnt_i = 1'b1;
        settle();
        chk("t3_m1_gnt", {31'b0, m1_gnt_o}, 32'd1);
        chk("t3_m0_wait", {31'b0, m0_gnt_o}, 32'd0);
        next_cycle();
        m1_req_i = 1'b0;
        settle();
        chk("t3_m0_gnt", {31'b0, m0_gnt_o}, 32'd1);
        chk("t3_m0_addr", {24'b0, s_addr_o}, 32'h40);
        next_cycle();
        m0_req_i   = 1'b0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        settle();
        chk("t3_rsp0_m1", {31'b0, m1_rvalid_o}, 32'd1);
        next_cycle();
        settle();
        chk("t3_rsp1_m0", {31'b0, m0_rvalid_o}, 32'd1);
        next_cycle();
        idle_inputs();

        // ---- FIFO full: third request blocked until a response frees a slot.
        do_reset();
        s_gnt_i  = 1'b1;
        m0_req_i = 1'b1; m0_addr_i = 8'h50;
        settle();
        chk("t4_acc0", {31'b0, m0_gnt_o}, 32'd1);
        next_cycle();
        m0_req_i = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 8'h60;
        settle();
        chk("t4_acc1", {31'b0, m1_gnt_o}, 32'd1);
        next_cycle();
        m1_req_i = 1'b0;
        m0_req_i = 1'b1; m0_addr_i = 8'h54;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("t4_full_req", {31'b0, s_req_o},  32'd0);
            chk("t4_full_gnt", {31'b0, m0_gnt_o}, 32'd0);
            next_cycle();
        end
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h1234_5678;
        settle();
        chk("t4_pop_req",    {31'b0, s_req_o},     32'd1);
        chk("t4_pop_gnt",    {31'b0, m0_gnt_o},    32'd1);
        chk("t4_pop_rvalid", {31'b0, m0_rvalid_o}, 32'd1);
        next_cycle();
        m0_req_i = 1'b0;
        settle();
        chk("t4_rsp_m1", {31'b0, m1_rvalid_o}, 32'd1);
        chk("t4_rsp_m1_not_m0", {31'b0, m0_rvalid_o}, 32'd0);
        next_cycle();
        settle();
        chk("t4_rsp_m0", {31'b0, m0_rvalid_o}, 32'd1);
        next_cycle();

        // ---- Stray response with nothing outstanding.
        settle();
        chk("t5_err",    {31'b0, err_o}, 32'd1);
        chk("t5_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        next_cycle();
        s_rvalid_i = 1'b0;
        settle();
        chk("t5_err_pulse", {31'b0, err_o}, 32'd0);
        next_cycle();
        s_rvalid_i = 1'b1;
        settle();
        chk("t5_still_empty", {31'b0, err_o}, 32'd1);
        next_cycle();
        idle_inputs();

        // ---- Reset with two outstanding: late response must be flagged, not routed.
        do_reset();
        s_gnt_i  = 1'b1;
        m0_req_i = 1'b1;
        next_cycle();
        m0_req_i = 1'b0;
        m1_req_i = 1'b1;
        next_cycle();
        m1_req_i = 1'b0;
        s_gnt_i  = 1'b0;
        rst_n    = 1'b0;
        m0_req_i = 1'b1;
        settle();
        chk("t6_rst_req", {31'b0, s_req_o}, 32'd0);
        next_cycle();
        rst_n    = 1'b1;
        m0_req_i = 1'b0;
        next_cycle();
        s_rvalid_i = 1'b1;
        settle();
        chk("t6_late_err",    {31'b0, err_o}, 32'd1);
        chk("t6_late_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        next_cycle();
        s_rvalid_i = 1'b0;
        m1_req_i   = 1'b1; m1_addr_i = 8'h77;
        s_gnt_i    = 1'b1;
        settle();
        chk("t6_m1_gnt",  {31'b0, m1_gnt_o}, 32'd1);
        chk("t6_m1_addr", {24'b0, s_addr_o}, 32'h77);
        next_cycle();
        m1_req_i   = 1'b0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        settle();
        chk("t6_m1_rvalid", {31'b0, m1_rvalid_o}, 32'd1);
        chk("t6_no_err",    {31'b0, err_o},       32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Two-master to one-slave request arbiter placed directly upstream of the single-port RAM.
- Merges an instruction-fetch port (m0) and a data port (m1) onto the RAM's req/gnt/rvalid port.
- Uses round-robin arbitration and holds the selected master while a request is stalled.
- Tracks outstanding transfers in an ID FIFO, so each rvalid/rdata returns to the master that issued it.

Parameters:
- ADDR_WIDTH, 8: address width on all ports.
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2: depth of the outstanding-ID FIFO; power of two, at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mN_req_i  in  1  request from master N (N = 0, 1).
- mN_addr_i  in  ADDR_WIDTH  byte address.
- mN_we_i  in  1  write enable.
- mN_wdata_i  in  DATA_WIDTH  write data.
- mN_be_i  in  DATA_WIDTH/8  byte enables.
- mN_gnt_o  out  1  request accepted this cycle.
- mN_rvalid_o  out  1  response valid for master N.
- mN_rdata_o  out  DATA_WIDTH  read data.
- s_req_o  out  1  request to the RAM.
- s_addr_o  out  ADDR_WIDTH  forwarded address.
- s_we_o  out  1  forwarded write enable.
- s_wdata_o  out  DATA_WIDTH  forwarded write data.
- s_be_o  out  DATA_WIDTH/8  forwarded byte enables.
- s_gnt_i  in  1  grant from the RAM.
- s_rvalid_i  in  1  response valid from the RAM; issued for reads and writes.
- s_rdata_i  in  DATA_WIDTH  read data from the RAM.
- err_o  out  1  one-cycle pulse when s_rvalid_i arrives with no outstanding transfer.

Behaviour:
- Reset (rst_n=0): round-robin pointer = 0 (m0 preferred), lock cleared, FIFO empty.
  - While rst_n=0, force s_req_o=0, m0/m1 gnt_o=0, rvalid_o=0, err_o=0.
- Accept event: s_req_o & s_gnt_i. At most one accept per cycle.
- Selection, computed combinationally:
  - If lock is set, sel = lock_id.
  - Otherwise, with both masters requesting, sel = rr_ptr.
  - Otherwise, sel = whichever master is requesting.
- s_req_o = mSEL_req_i & can_issue.
  - can_issue = !fifo_full | pop, where pop = s_rvalid_i & !fifo_empty.
  - A same-cycle pop frees the slot, so back-to-back streaming runs at 1 transfer/cycle with MAX_OUTSTANDING >= 1.
- s_addr/we/wdata/be_o mux from the selected master. They are driven from the selected master even when s_req_o=0.
- mSEL_gnt_o = s_gnt_i & s_req_o. The unselected master's gnt_o = 0.
- Lock: set, with lock_id = sel, when s_req_o & !s_gnt_i. Clear on accept. A stalled request is never re-steered.
- Round-robin: on accept from master k, rr_ptr <= ~k.
- FIFO:
  - Push sel on accept; pop on s_rvalid_i when non-empty.
  - Simultaneous push and pop is legal at any occupancy, including full.
- Response routing:
  - mH_rvalid_o = s_rvalid_i & !fifo_empty, where H = FIFO head; the other master's rvalid_o = 0.
  - m0_rdata_o = m1_rdata_o = s_rdata_i. Masters qualify rdata with their rvalid_o.
- Latency: zero added cycles on request and on response paths, which are purely combinational muxing. Only pointer, lock and FIFO state are registered.
- Stray s_rvalid_i with the FIFO empty: no rvalid to either master, err_o pulses for 1 cycle, no state change.
- Master protocol: req and payload held stable until gnt. A master dropping req before gnt is a protocol violation; behaviour is undefined beyond dropping s_req_o.
- Reset mid-operation: all outstanding IDs are discarded. Any late s_rvalid_i after reset release raises err_o.

Decomposition:
- Package mem_arb_pkg:
  - typedef logic mst_id_t (1 bit).
  - localparams MST_I = 1'b0, MST_D = 1'b1.
  - function rr_next(mst_id_t) returning the inverted ID.
- Sub-module mem_arb_id_fifo:
  - Parameterised DEPTH and a mst_id_t payload; push/pop/full/empty/head.
  - Wrap-around pointers with a count register; asynchronous active-low reset.
- Top level holds the select, lock and round-robin logic, about 150 lines plus about 80 lines for the FIFO.

Test Plan:
- m0 read only, addr 0x10, RAM grants immediately, rvalid next cycle with rdata 0xDEADBEEF -> m0_gnt=1 in cycle 0; m0_rvalid=1 with 0xDEADBEEF in cycle 1; m1_rvalid stays 0.
- Both masters request continuously for 6 cycles after reset -> grants alternate m0,m1,m0,m1,m0,m1; responses route in the same order; 1 transfer/cycle.
- m1 requests, s_gnt_i held 0 for 3 cycles while m0 also requests -> s_addr_o stays m1's address all 3 cycles; m1 is granted in cycle 4; m0 is granted in cycle 5.
- MAX_OUTSTANDING=2, RAM withholds rvalid for 2 accepted transfers -> third request sees s_req_o=0 until s_rvalid_i, then issues in that same cycle.
- s_rvalid_i pulsed with the FIFO empty -> err_o=1 for one cycle; both rvalid_o=0; FIFO remains empty.
- rst_n asserted with 2 outstanding, released, then s_rvalid_i -> err_o=1; no rvalid to either master; next m1 request is granted normally.
